// File: rtl/alu_result_display_if.sv
// Bundle between the ALU result display stage and its surroundings: live ALU
// result/flags and the raw load button in, multiplexed 7-segment drive out.
interface alu_result_display_if;
    logic [7:0] alures;
    logic       ZF;
    logic       OF;
    logic       load_btn;
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;

    // There is no valid/ready pair: alures/ZF/OF are level inputs that are
    // sampled only on a debounced press of load_btn.
    modport master (
        output alures,
        output ZF,
        output OF,
        output load_btn,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  alures,
        input  ZF,
        input  OF,
        input  load_btn,
        output an,
        output seg,
        output dp
    );
endinterface

// File: rtl/alu_result_display.sv
// ALU result display: debounced load button captures alures/ZF/OF, and the held
// values are scanned onto an 8-digit active-low 7-segment display.
module alu_result_display #(
    parameter int unsigned SCAN_DIV        = 100000,
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst,
    alu_result_display_if.slave bus
);

    localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

    // Button synchronizer and debouncer
    logic            btn_meta;
    logic            btn_s;
    logic [DB_W-1:0] db_cnt;
    logic            db_level;
    logic            db_prev;
    logic            cap_pulse;

    // Held values
    logic [7:0] held_res;
    logic       held_zf;
    logic       held_of;
    logic       stale;

    // Scan state and registered display outputs
    logic [SCAN_W-1:0] scan_cnt;
    logic [2:0]        idx;
    logic [7:0]        an_r;
    logic [6:0]        seg_r;
    logic              dp_r;

    // Decoded drive for the slot selected by idx
    logic [7:0] slot_an;
    logic [6:0] slot_seg;
    logic       slot_dp;

    function automatic logic [6:0] hex_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            db_cnt   <= '0;
            db_level <= 1'b0;
            db_prev  <= 1'b0;
        end else begin
            btn_meta <= bus.load_btn;
            btn_s    <= btn_meta;
            db_prev  <= db_level;
            // Any sample agreeing with the accepted level restarts the count.
            if (btn_s == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign cap_pulse = db_level & ~db_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_res <= 8'h00;
            held_zf  <= 1'b0;
            held_of  <= 1'b0;
        end else if (cap_pulse) begin
            held_res <= bus.alures;
            held_zf  <= bus.ZF;
            held_of  <= bus.OF;
        end
    end

    assign stale = ({bus.alures, bus.ZF, bus.OF} != {held_res, held_zf, held_of});

    always_comb begin
        slot_an  = 8'hFF;
        slot_seg = 7'h7F;
        slot_dp  = 1'b1;
        case (idx)
            3'd0: begin
                slot_an  = 8'hFE;
                slot_seg = hex_seg(held_res[3:0]);
                slot_dp  = ~stale;
            end
            3'd1: begin
                slot_an  = 8'hFD;
                slot_seg = hex_seg(held_res[7:4]);
            end
            3'd4: begin
                slot_an  = 8'hEF;
                slot_seg = hex_seg({3'b000, held_zf});
            end
            3'd5: begin
                slot_an  = 8'hDF;
                slot_seg = hex_seg({3'b000, held_of});
            end
            default: begin
                // Unused digits stay dark with their anode released.
                slot_an  = 8'hFF;
                slot_seg = 7'h7F;
                slot_dp  = 1'b1;
            end
        endcase
    end

    // At each wrap the outputs latch the slot idx points at, then idx advances,
    // so the first wrap after reset lights d0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= 3'd0;
            an_r     <= 8'hFF;
            seg_r    <= 7'h7F;
            dp_r     <= 1'b1;
        end else if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 3'd1;
            an_r     <= slot_an;
            seg_r    <= slot_seg;
            dp_r     <= slot_dp;
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    assign bus.an  = an_r;
    assign bus.seg = seg_r;
    assign bus.dp  = dp_r;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed bench for alu_result_display with a short scan period and debounce
// window so every digit slot and capture path is reached quickly.
module tb_alu_result_display;

    logic clk;
    logic rst;
    int   tests_run;
    int   failed;
    logic [7:0] an_exp [8];

    alu_result_display_if dut_if ();

    alu_result_display #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (dut_if)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        tests_run++;
        assert (obs === exp_v) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Wait for the next fresh entry into slot d0, bounded.
    task automatic goto_d0(input string tag);
        int n;
        n = 0;
        while (dut_if.an == 8'hFE && n < 80) begin
            @(negedge clk);
            n++;
        end
        while (dut_if.an != 8'hFE && n < 80) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_reach_d0"}, dut_if.an, 8'hFE);
    endtask

    task automatic check_scan(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                              input logic [6:0] s4, input logic [6:0] s5, input logic dp0);
        logic [6:0] seg_exp [8];
        seg_exp[0] = s0;
        seg_exp[1] = s1;
        seg_exp[2] = 7'h7F;
        seg_exp[3] = 7'h7F;
        seg_exp[4] = s4;
        seg_exp[5] = s5;
        seg_exp[6] = 7'h7F;
        seg_exp[7] = 7'h7F;
        goto_d0(tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s_d%0d_an", tag, i), dut_if.an, an_exp[i]);
            chk($sformatf("%s_d%0d_seg", tag, i), {1'b0, dut_if.seg}, {1'b0, seg_exp[i]});
            chk($sformatf("%s_d%0d_dp", tag, i), {7'b0, dut_if.dp},
                {7'b0, (i == 0) ? dp0 : 1'b1});
            repeat (4) @(negedge clk);
        end
        chk({tag, "_wrap_an"}, dut_if.an, 8'hFE);
    endtask

    task automatic press(input int hold);
        dut_if.load_btn = 1'b1;
        repeat (hold) @(negedge clk);
        dut_if.load_btn = 1'b0;
        repeat (16) @(negedge clk);
    endtask

    initial begin
        tests_run = 0;
        failed    = 0;
        an_exp[0] = 8'hFE;
        an_exp[1] = 8'hFD;
        an_exp[2] = 8'hFF;
        an_exp[3] = 8'hFF;
        an_exp[4] = 8'hEF;
        an_exp[5] = 8'hDF;
        an_exp[6] = 8'hFF;
        an_exp[7] = 8'hFF;

        rst             = 1'b1;
        dut_if.alures   = 8'h00;
        dut_if.ZF       = 1'b0;
        dut_if.OF       = 1'b0;
        dut_if.load_btn = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // 1: reset mid-scan, then first wrap lights d0
        repeat (6) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_an", dut_if.an, 8'hFF);
        chk("rst_seg", {1'b0, dut_if.seg}, 8'h7F);
        chk("rst_dp", {7'b0, dut_if.dp}, 8'h01);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pre_wrap_an", dut_if.an, 8'hFF);
        @(negedge clk);
        chk("rst_wrap_an", dut_if.an, 8'hFE);
        chk("rst_wrap_seg", {1'b0, dut_if.seg}, 8'h40);
        chk("rst_wrap_dp", {7'b0, dut_if.dp}, 8'h01);

        // 2: clean press captures once; hold and release add nothing
        dut_if.alures   = 8'h3C;
        dut_if.ZF       = 1'b0;
        dut_if.OF       = 1'b1;
        dut_if.load_btn = 1'b1;
        repeat (15) @(negedge clk);
        dut_if.alures = 8'h55;
        repeat (10) @(negedge clk);
        dut_if.load_btn = 1'b0;
        repeat (16) @(negedge clk);
        check_scan("cap3c", 7'h46, 7'h30, 7'h40, 7'h79, 1'b0);

        // 3: bouncing button is rejected, stable press is accepted
        dut_if.alures = 8'hA7;
        dut_if.ZF     = 1'b1;
        dut_if.OF     = 1'b0;
        for (int t = 0; t < 10; t++) begin
            dut_if.load_btn = ~dut_if.load_btn;
            repeat (3) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        check_scan("bounce", 7'h46, 7'h30, 7'h40, 7'h79, 1'b0);
        press(20);
        check_scan("capa7", 7'h78, 7'h08, 7'h79, 7'h40, 1'b1);

        // 4: stale decimal point only in d0
        dut_if.alures = 8'h00;
        dut_if.ZF     = 1'b1;
        dut_if.OF     = 1'b0;
        press(20);
        check_scan("cap00", 7'h40, 7'h40, 7'h79, 7'h40, 1'b1);
        dut_if.alures = 8'h01;
        check_scan("stale", 7'h40, 7'h40, 7'h79, 7'h40, 1'b0);
        dut_if.alures = 8'h00;
        check_scan("fresh", 7'h40, 7'h40, 7'h79, 7'h40, 1'b1);

        // 5: all hex digits of F8 and full index wrap
        dut_if.alures = 8'hF8;
        dut_if.ZF     = 1'b0;
        dut_if.OF     = 1'b0;
        press(20);
        check_scan("capf8", 7'h00, 7'h0E, 7'h40, 7'h40, 1'b1);

        // 6: reset during debounce discards the partial count
        dut_if.alures   = 8'h96;
        dut_if.ZF       = 1'b1;
        dut_if.OF       = 1'b1;
        dut_if.load_btn = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst2_an", dut_if.an, 8'hFF);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        dut_if.alures = 8'h69;
        repeat (3) @(negedge clk);
        dut_if.alures = 8'h5A;
        repeat (5) @(negedge clk);
        dut_if.load_btn = 1'b0;
        repeat (16) @(negedge clk);
        check_scan("rstdb", 7'h10, 7'h02, 7'h79, 7'h79, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
